// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes it into instruction memory.
// It holds the pipeline in reset until a complete image with a good checksum has been written.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           word_count
);

    localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR
    } stateT;

    stateT       state, stateNext;
    logic [7:0]  checksum;
    logic [1:0]  byteIdx;
    logic [15:0] wordIdx;
    logic [23:0] asmReg;

    logic        accept;
    logic        startLoad;
    logic [15:0] lenFull;
    logic        lastWord;

    assign accept    = byte_valid & byte_ready;
    assign startLoad = start & (state == IDLE || state == DONE || state == ERROR);
    assign lenFull   = {word_count[15:8], byte_in};
    assign lastWord  = (wordIdx == word_count - 16'd1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext  = state;
        byte_ready = 1'b0;
        core_reset = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            IDLE:   if (start) stateNext = LEN_HI;
            LEN_HI: begin
                byte_ready = 1'b1;
                if (accept) stateNext = LEN_LO;
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                if (accept) begin
                    if ({1'b0, lenFull} > MaxWords) stateNext = ERROR;
                    else if (lenFull == 16'd0)      stateNext = CHECK;
                    else                            stateNext = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (accept && byteIdx == 2'd3 && lastWord) stateNext = CHECK;
            end
            CHECK: begin
                byte_ready = 1'b1;
                if (accept) stateNext = (byte_in == checksum) ? DONE : ERROR;
            end
            DONE: begin
                core_reset = 1'b0;
                load_done  = 1'b1;
                if (start) stateNext = LEN_HI;
            end
            ERROR: begin
                load_error = 1'b1;
                if (start) stateNext = LEN_HI;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            checksum   <= '0;
            byteIdx    <= '0;
            wordIdx    <= '0;
            asmReg     <= '0;
        end else begin
            imem_we <= 1'b0;
            if (startLoad) begin
                checksum <= '0;
                byteIdx  <= '0;
                wordIdx  <= '0;
            end
            // The checksum byte itself is not folded in; the frame bytes before it are.
            if (accept && state != CHECK) checksum <= checksum ^ byte_in;
            if (accept) begin
                case (state)
                    LEN_HI: word_count[15:8] <= byte_in;
                    LEN_LO: word_count[7:0]  <= byte_in;
                    DATA: begin
                        asmReg  <= {asmReg[15:0], byte_in};
                        byteIdx <= byteIdx + 2'd1;
                        if (byteIdx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wordIdx[ADDR_WIDTH-1:0];
                            imem_wdata <= {asmReg, byte_in};
                            wordIdx    <= wordIdx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad checksum, oversize and empty images, gapped stream, mid-load reset.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0]  wrAddr[$];
    logic [31:0] wrData[$];

    logic [7:0] goodFrame[$] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
    logic [7:0] badFrame[$]  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0D};

    imem_boot_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wrAddr.push_back(imem_addr);
            wrData.push_back(imem_wdata);
        end
    end

    task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] frame[$]);
        foreach (frame[i]) sendByte(frame[i]);
    endtask

    task automatic clearWrites();
        wrAddr.delete();
        wrData.delete();
    endtask

    task automatic checkGoodWrites(input string tag);
        expect32({tag, "_nwrites"}, wrAddr.size(), 2);
        if (wrAddr.size() == 2) begin
            expect32({tag, "_addr0"}, wrAddr[0], 0);
            expect32({tag, "_data0"}, wrData[0], 32'h2008_0005);
            expect32({tag, "_addr1"}, wrAddr[1], 1);
            expect32({tag, "_data1"}, wrData[1], 32'h2009_000A);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect32("rst_byte_ready", byte_ready, 0);
        expect32("rst_imem_we", imem_we, 0);
        expect32("rst_imem_addr", imem_addr, 0);
        expect32("rst_imem_wdata", imem_wdata, 0);
        expect32("rst_core_reset", core_reset, 1);
        expect32("rst_load_done", load_done, 0);
        expect32("rst_load_error", load_error, 0);
        expect32("rst_word_count", word_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        expect32("idle_byte_ready", byte_ready, 0);
        expect32("idle_core_reset", core_reset, 1);
    endtask

    task automatic test_good_load();
        clearWrites();
        pulseStart();
        expect32("t1_ready_lenhi", byte_ready, 1);
        for (int i = 0; i < 6; i++) sendByte(goodFrame[i]);
        expect32("t1_we_latency", imem_we, 1);
        expect32("t1_addr_latency", imem_addr, 0);
        expect32("t1_wdata_latency", imem_wdata, 32'h2008_0005);
        for (int i = 6; i < 11; i++) sendByte(goodFrame[i]);
        expect32("t1_load_done", load_done, 1);
        expect32("t1_load_error", load_error, 0);
        expect32("t1_core_reset", core_reset, 0);
        expect32("t1_word_count", word_count, 2);
        expect32("t1_ready_done", byte_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        checkGoodWrites("t1");
        expect32("t1_hold_addr", imem_addr, 1);
        expect32("t1_hold_wdata", imem_wdata, 32'h2009_000A);
    endtask

    task automatic test_bad_checksum();
        clearWrites();
        pulseStart();
        expect32("t2_core_reset_reheld", core_reset, 1);
        expect32("t2_done_cleared", load_done, 0);
        sendFrame(badFrame);
        expect32("t2_load_error", load_error, 1);
        expect32("t2_load_done", load_done, 0);
        expect32("t2_core_reset", core_reset, 1);
        repeat (3) @(posedge clk);
        #1;
        expect32("t2_error_sticky", load_error, 1);
        clearWrites();
        pulseStart();
        expect32("t2_error_cleared", load_error, 0);
        sendFrame(goodFrame);
        expect32("t2_reload_done", load_done, 1);
        expect32("t2_reload_core_reset", core_reset, 0);
        @(posedge clk); #1;
        checkGoodWrites("t2");
    endtask

    task automatic test_oversize();
        clearWrites();
        pulseStart();
        sendByte(8'h01);
        sendByte(8'h01);
        expect32("t3_load_error", load_error, 1);
        expect32("t3_byte_ready", byte_ready, 0);
        expect32("t3_word_count", word_count, 16'h0101);
        sendByte(8'h20);
        sendByte(8'h08);
        repeat (2) @(posedge clk);
        #1;
        expect32("t3_no_writes", wrAddr.size(), 0);
        expect32("t3_still_error", load_error, 1);
    endtask

    task automatic test_zero_len();
        clearWrites();
        pulseStart();
        sendByte(8'h00);
        sendByte(8'h00);
        expect32("t4_check_ready", byte_ready, 1);
        sendByte(8'h00);
        expect32("t4_done", load_done, 1);
        expect32("t4_core_reset", core_reset, 0);
        pulseStart();
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h01);
        expect32("t4_bad_error", load_error, 1);
        expect32("t4_bad_done", load_done, 0);
        @(posedge clk); #1;
        expect32("t4_no_writes", wrAddr.size(), 0);
    endtask

    task automatic test_back_to_back_gaps();
        clearWrites();
        pulseStart();
        foreach (goodFrame[i]) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                byte_in    = 8'($urandom);
                byte_valid = 1'b0;
                start      = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (i == 4) start = 1'b1;
            sendByte(goodFrame[i]);
            start = 1'b0;
        end
        expect32("t5_load_done", load_done, 1);
        expect32("t5_core_reset", core_reset, 0);
        expect32("t5_word_count", word_count, 2);
        @(posedge clk); #1;
        checkGoodWrites("t5");
    endtask

    task automatic test_reset_mid_load();
        clearWrites();
        pulseStart();
        for (int i = 0; i < 8; i++) sendByte(goodFrame[i]);
        reset = 1'b1;
        #1;
        expect32("t6_core_reset", core_reset, 1);
        expect32("t6_imem_we", imem_we, 0);
        expect32("t6_imem_addr", imem_addr, 0);
        expect32("t6_imem_wdata", imem_wdata, 0);
        expect32("t6_word_count", word_count, 0);
        expect32("t6_byte_ready", byte_ready, 0);
        expect32("t6_load_done", load_done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        clearWrites();
        pulseStart();
        sendFrame(goodFrame);
        expect32("t6_reload_done", load_done, 1);
        expect32("t6_reload_core_reset", core_reset, 0);
        @(posedge clk); #1;
        checkGoodWrites("t6");
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_oversize();
        test_zero_len();
        test_back_to_back_gaps();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
